posit_decode_arbiter: RTL
=========================

POSIT_DECODE_ARBITER -- requirements
Module: posit_decode_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 48, max cycles WAIT_DONE holds before declaring a decode error.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester n has a posit to decode.
REQ-005 req0_posit / req1_posit  input  32  posit word of requester n.
REQ-006 req0_ready / req1_ready  output  1  request n accepted this cycle (valid&&ready = handshake).
REQ-007 resp_valid  output  1  decoded result present.
REQ-008 resp_ready  input  1  consumer accepts result.
REQ-009 resp_id  output  1  requester that owns the result.
REQ-010 resp_sign, resp_zero, resp_nar, resp_err  output  1 each  decoded flags; err = timeout.
REQ-011 resp_k  output  6  signed regime value; resp_exp output 3; resp_mant output 32.
REQ-012 dec_posit  output  32  operand to shared decoder; dec_start, dec_received  output 1.
REQ-013 dec_done, dec_sign, dec_zero, dec_nar  input 1; dec_k input 6 signed; dec_exp input 3; dec_mant input 32.
REQ-014 busy  output  1  high in any state except IDLE.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT_DONE, RELEASE, RESP.
REQ-016 IDLE: if any req valid, grant one, pulse that reqN_ready for exactly one cycle, latch posit and id, go ISSUE; else stay.
REQ-017 Arbitration SHALL be round-robin: pointer favours req0 after reset; after each grant pointer points to the other requester.
REQ-018 Simultaneous valids: pointer holder wins; single valid wins regardless of pointer.
REQ-019 reqN_ready SHALL be 0 in every state except the IDLE grant cycle.
REQ-020 ISSUE: dec_posit = latched posit, dec_start = 1 for one cycle, go WAIT_DONE; dec_posit held stable from ISSUE through RELEASE.
REQ-021 WAIT_DONE: 6-bit counter increments per cycle; on dec_done=1 capture all dec_* fields into resp registers, resp_err=0, go RELEASE.
REQ-022 WAIT_DONE timeout: counter reaching TIMEOUT without dec_done -> resp fields zero, resp_err=1, go RELEASE.
REQ-023 RELEASE: dec_received = 1 held until dec_done observed 0, then go RESP (guarantees decoder back in its idle state before next ISSUE).
REQ-024 RESP: resp_valid=1, resp fields stable until resp_valid&&resp_ready; then resp_valid=0 next cycle, go IDLE.
REQ-025 Minimum grant-to-grant spacing: decoder latency + 4 cycles; no back-to-back issue without passing IDLE.
REQ-026 dec_start and dec_received SHALL never both be 1 in the same cycle.
REQ-027 Requester posit changes after handshake SHALL NOT affect the in-flight decode.

Reset
REQ-028 On rst low: state IDLE, pointer = req0, counter 0, all outputs 0 (resp_*, reqN_ready, dec_start, dec_received, dec_posit, busy).
REQ-029 Reset mid-operation SHALL abort the decode and drop resp_valid immediately; no partial result emitted.

Structure
REQ-030 State encodings, TIMEOUT default, field widths (K_W=6, EXP_W=3, MANT_W=32) SHALL live in shared package posit_pkg.
REQ-031 Arbiter SHALL be a single module; decoder instantiated outside it; optional sub-module rr_arb2 for the 2-way round-robin grant.

Verification
REQ-032 Single request: req0 posit 32'h40000000 -> one ISSUE, resp_id 0, sign 0, k 0, exp 0, mant 32'h80000000, err 0.
REQ-033 Simultaneous: both valid from reset with 32'h40000000 / 32'hC0000000 -> req0 served first, then req1 (sign 1); third simultaneous pair -> req0 again.
REQ-034 Zero/NaR: 32'h00000000 -> resp_zero 1; 32'h80000000 -> resp_nar 1; arbiter returns to IDLE both times.
REQ-035 Backpressure: hold resp_ready 0 for 10 cycles -> resp_valid and fields stable, no reqN_ready pulse, busy 1.
REQ-036 Timeout: decoder model never asserts dec_done -> after 48 WAIT_DONE cycles resp_err 1, fields 0, dec_received asserted.
REQ-037 Reset in WAIT_DONE: rst low for 2 cycles -> all outputs 0, next request served normally from req0.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared widths, state encoding and result payload for the posit decode arbiter.
package posit_pkg;

    localparam int unsigned POSIT_W     = 32;
    localparam int unsigned K_W         = 6;
    localparam int unsigned EXP_W       = 3;
    localparam int unsigned MANT_W      = 32;
    localparam int unsigned CNT_W       = 6;
    localparam int unsigned TIMEOUT_DEF = 48;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RESP      = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic             sign;
        logic             zero;
        logic             nar;
        logic             err;
        logic [K_W-1:0]   k;
        logic [EXP_W-1:0] expo;
        logic [MANT_W-1:0] mant;
    } dec_result_t;

    // Result reported when the decoder never answers: all fields cleared, err set.
    localparam dec_result_t RES_TIMEOUT = '{
        sign: 1'b0, zero: 1'b0, nar: 1'b0, err: 1'b1,
        k: '0, expo: '0, mant: '0
    };

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: pointer holder wins a tie, a lone requester always wins.
module rr_arb2 (
    input  logic       i_ptr,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt_c
);

    // One-hot grant from the request pair and the priority pointer
    always_comb begin
        o_gnt_c = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt_c = i_ptr ? 2'b10 : 2'b01;
        end else begin
            o_gnt_c = i_req;
        end
    end

endmodule

// File: rtl/posit_decode_arbiter.sv
// Arbitrates two posit requesters onto one shared external decoder and returns
// the decoded fields with the owning requester id.
module posit_decode_arbiter
    import posit_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [POSIT_W-1:0]       req0_posit,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [POSIT_W-1:0]       req1_posit,
    output logic                     req1_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_id,
    output logic                     resp_sign,
    output logic                     resp_zero,
    output logic                     resp_nar,
    output logic                     resp_err,
    output logic signed [K_W-1:0]    resp_k,
    output logic [EXP_W-1:0]         resp_exp,
    output logic [MANT_W-1:0]        resp_mant,
    output logic [POSIT_W-1:0]       dec_posit,
    output logic                     dec_start,
    output logic                     dec_received,
    input  logic                     dec_done,
    input  logic                     dec_sign,
    input  logic                     dec_zero,
    input  logic                     dec_nar,
    input  logic signed [K_W-1:0]    dec_k,
    input  logic [EXP_W-1:0]         dec_exp,
    input  logic [MANT_W-1:0]        dec_mant,
    output logic                     busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t          r_state;
    logic                r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_id;
    logic [POSIT_W-1:0]  r_posit;
    logic [1:0]          r_req_ready;
    logic                r_dec_start;
    logic                r_dec_received;
    logic                r_resp_valid;
    logic                r_busy;
    dec_result_t         r_res;
    logic [1:0]          w_gnt;

    rr_arb2 u_rr_arb2 (
        .i_ptr   (r_ptr),
        .i_req   ({req1_valid, req0_valid}),
        .o_gnt_c (w_gnt)
    );

    // Grant, issue, wait, release and respond sequence with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_ptr          <= 1'b0;
            r_cnt          <= '0;
            r_id           <= 1'b0;
            r_posit        <= '0;
            r_req_ready    <= 2'b00;
            r_dec_start    <= 1'b0;
            r_dec_received <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_busy         <= 1'b0;
            r_res          <= '0;
        end else begin
            r_req_ready <= 2'b00;
            r_dec_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_req_ready <= w_gnt;
                        r_id        <= w_gnt[1];
                        r_posit     <= w_gnt[1] ? req1_posit : req0_posit;
                        r_ptr       <= w_gnt[0];
                        r_dec_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (dec_done) begin
                        r_res          <= {dec_sign, dec_zero, dec_nar, 1'b0, dec_k, dec_exp, dec_mant};
                        r_dec_received <= 1'b1;
                        r_state        <= ST_RELEASE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_res          <= RES_TIMEOUT;
                        r_dec_received <= 1'b1;
                        r_state        <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Hold the acknowledge until the decoder has dropped done
                    if (!dec_done) begin
                        r_dec_received <= 1'b0;
                        r_resp_valid   <= 1'b1;
                        r_state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready   = r_req_ready[0];
    assign req1_ready   = r_req_ready[1];
    assign dec_posit    = r_posit;
    assign dec_start    = r_dec_start;
    assign dec_received = r_dec_received;
    assign resp_valid   = r_resp_valid;
    assign resp_id      = r_id;
    assign resp_sign    = r_res.sign;
    assign resp_zero    = r_res.zero;
    assign resp_nar     = r_res.nar;
    assign resp_err     = r_res.err;
    assign resp_k       = r_res.k;
    assign resp_exp     = r_res.expo;
    assign resp_mant    = r_res.mant;
    assign busy         = r_busy;

endmodule
